// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch stage: redirect kinds,
// FSM state encodings and immediate field widths.
package ifetch_pkg;

   localparam logic [1:0] REDIR_NONE   = 2'b00;
   localparam logic [1:0] REDIR_BRANCH = 2'b01;
   localparam logic [1:0] REDIR_JUMP   = 2'b10;
   localparam logic [1:0] REDIR_JR     = 2'b11;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam int IMM16_W = 16;
   localparam int IMM26_W = 26;

endpackage

// File: rtl/ifetch_next_pc_calc.sv
// Combinational redirect target: PC-relative branch, absolute jump within
// the current 256 MB region, or register-indirect jump.
module next_pc_calc
   import ifetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            redir_type,
   input  logic [DATA_WIDTH-1:0] pc_plus4,
   input  logic [IMM16_W-1:0]    imm16,
   input  logic [IMM26_W-1:0]    imm26,
   input  logic [DATA_WIDTH-1:0] reg_value,
   output logic [DATA_WIDTH-1:0] target
);

   logic signed [DATA_WIDTH-1:0] branch_offset;

   assign branch_offset = {{(DATA_WIDTH-IMM16_W-2){imm16[IMM16_W-1]}}, imm16, 2'b00};

   always_comb begin
      target = pc_plus4;
      case (redir_type)
         REDIR_BRANCH: target = pc_plus4 + branch_offset;
         REDIR_JUMP:   target = {pc_plus4[31:28], imm26, 2'b00};
         REDIR_JR:     target = {reg_value[31:2], 2'b00};
         default:      target = pc_plus4;
      endcase
   end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, runs req/ack transactions to
// instruction memory and hands words to the decoder over valid/ready.
module ifetch
   import ifetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_3000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instruction,
   output logic [DATA_WIDTH-1:0] out_pc,
   input  logic                  redirect_valid,
   input  logic [1:0]            redirect_type,
   input  logic [DATA_WIDTH-1:0] redirect_pc_plus4,
   input  logic [IMM16_W-1:0]    redirect_imm16,
   input  logic [IMM26_W-1:0]    redirect_imm26,
   input  logic [DATA_WIDTH-1:0] redirect_reg
);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] pc;
   logic                  drop;
   logic [DATA_WIDTH-1:0] target;
   logic                  redir;

   function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] a);
      return {a[DATA_WIDTH-1:2], 2'b00};
   endfunction

   assign redir = redirect_valid && (redirect_type != REDIR_NONE);

   next_pc_calc #(.DATA_WIDTH(DATA_WIDTH)) u_next_pc (
      .redir_type (redirect_type),
      .pc_plus4   (redirect_pc_plus4),
      .imm16      (redirect_imm16),
      .imm26      (redirect_imm26),
      .reg_value  (redirect_reg),
      .target     (target)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= ST_BOOT;
         pc              <= RESET_PC;
         drop            <= 1'b0;
         imem_req        <= 1'b0;
         imem_addr       <= '0;
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_pc          <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
               if (redir) begin
                  pc        <= target;
                  imem_addr <= align_word(target);
               end else begin
                  imem_addr <= align_word(pc);
               end
            end
            ST_FETCH: begin
               if (redir) begin
                  pc <= target;
                  if (imem_req && imem_ack) begin
                     // Wrong-path word arrives with the redirect: idle one cycle.
                     imem_req <= 1'b0;
                     drop     <= 1'b0;
                  end else if (imem_req) begin
                     drop <= 1'b1;
                  end else begin
                     imem_req  <= 1'b1;
                     imem_addr <= align_word(target);
                  end
               end else if (!imem_req) begin
                  imem_req  <= 1'b1;
                  imem_addr <= align_word(pc);
               end else if (imem_ack) begin
                  if (drop) begin
                     // Squashed response; reissue at the redirected PC.
                     drop      <= 1'b0;
                     imem_addr <= align_word(pc);
                  end else begin
                     out_instruction <= imem_rdata;
                     out_pc          <= pc;
                     out_valid       <= 1'b1;
                     pc              <= pc + 32'd4;
                     imem_req        <= 1'b0;
                     state           <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (redir) begin
                  out_valid <= 1'b0;
                  pc        <= target;
                  state     <= ST_FETCH;
                  imem_req  <= 1'b1;
                  imem_addr <= align_word(target);
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_FETCH;
                  imem_req  <= 1'b1;
                  imem_addr <= align_word(pc);
               end
            end
            default: begin
               state    <= ST_BOOT;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a configurable-latency memory model.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [1:0]  redirect_type;
   logic [31:0] redirect_pc_plus4;
   logic [15:0] redirect_imm16;
   logic [25:0] redirect_imm26;
   logic [31:0] redirect_reg;

   logic        auto_mode;
   logic [3:0]  mem_delay;
   logic        man_ack;
   logic [3:0]  cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ifetch dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ack          (imem_ack),
      .imem_rdata        (imem_rdata),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_instruction   (out_instruction),
      .out_pc            (out_pc),
      .redirect_valid    (redirect_valid),
      .redirect_type     (redirect_type),
      .redirect_pc_plus4 (redirect_pc_plus4),
      .redirect_imm16    (redirect_imm16),
      .redirect_imm26    (redirect_imm26),
      .redirect_reg      (redirect_reg)
   );

   // Memory: acks after mem_delay wait cycles, aborts on reset.
   always_ff @(posedge clk) begin
      if (!rst_n || !imem_req || imem_ack) cnt <= '0;
      else cnt <= cnt + 4'd1;
   end
   assign imem_ack   = auto_mode ? (imem_req && (cnt == mem_delay)) : man_ack;
   assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic ck(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      total++; if (out_instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", out_instruction); end
      total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] a;
      auto_mode = 1'b1; mem_delay = 4'd0; out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a = 32'h3000 + 32'(4 * i);
         step();
         total++; if (imem_req !== 1'b1 || imem_addr !== a || out_valid !== 1'b0) begin
            bad++; $display("FAIL zw_req[%0d] got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0", i, imem_req, imem_addr, out_valid, a);
         end
         step();
         total++; if (out_valid !== 1'b1 || out_pc !== a || out_instruction !== (a ^ 32'hDEAD_0000) || imem_req !== 1'b0) begin
            bad++; $display("FAIL zw_out[%0d] got valid=%b pc=%h instr=%h req=%b exp valid=1 pc=%h instr=%h req=0",
                            i, out_valid, out_pc, out_instruction, imem_req, a, a ^ 32'hDEAD_0000);
         end
      end
   endtask

   task automatic test_wait_states();
      auto_mode = 1'b1; mem_delay = 4'd2; out_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || out_valid !== 1'b0) begin
            bad++; $display("FAIL ws_hold[%0d] got req=%b addr=%h valid=%b exp req=1 addr=00003000 valid=0", k, imem_req, imem_addr, out_valid);
         end
      end
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instruction !== 32'hDEAD_3000) begin
         bad++; $display("FAIL ws_out got valid=%b pc=%h instr=%h exp valid=1 pc=00003000 instr=dead3000", out_valid, out_pc, out_instruction);
      end
      step();
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3004) begin
         bad++; $display("FAIL ws_next got valid=%b req=%b addr=%h exp valid=0 req=1 addr=00003004", out_valid, imem_req, imem_addr);
      end
      step();
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ws_single got valid=%b exp 0", out_valid); end
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h3004) begin
         bad++; $display("FAIL ws_out2 got valid=%b pc=%h exp valid=1 pc=00003004", out_valid, out_pc);
      end
   endtask

   task automatic test_hold_stall();
      auto_mode = 1'b1; mem_delay = 4'd0; out_ready = 1'b0;
      do_reset();
      step();
      step();
      redirect_valid = 1'b1; redirect_type = 2'b00; redirect_reg = 32'h5555_5555;
      for (int k = 0; k < 5; k++) begin
         step();
         total++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instruction !== 32'hDEAD_3000 || imem_req !== 1'b0) begin
            bad++; $display("FAIL stall[%0d] got valid=%b pc=%h instr=%h req=%b exp valid=1 pc=00003000 instr=dead3000 req=0",
                            k, out_valid, out_pc, out_instruction, imem_req);
         end
      end
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      step();
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3004) begin
         bad++; $display("FAIL stall_rel got valid=%b req=%b addr=%h exp valid=0 req=1 addr=00003004", out_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_branch();
      auto_mode = 1'b0; man_ack = 1'b0; out_ready = 1'b1;
      do_reset();
      step();
      redirect_valid = 1'b1; redirect_type = 2'b01; redirect_pc_plus4 = 32'h3010; redirect_imm16 = 16'hFFFC;
      step();
      redirect_valid = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
         bad++; $display("FAIL br_keep got req=%b addr=%h exp req=1 addr=00003000", imem_req, imem_addr);
      end
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
         bad++; $display("FAIL br_drop got valid=%b req=%b addr=%h exp valid=0 req=1 addr=00003000", out_valid, imem_req, imem_addr);
      end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL br_quiet got valid=%b exp 0", out_valid); end
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin
         bad++; $display("FAIL br_out got valid=%b pc=%h exp valid=1 pc=00003000", out_valid, out_pc);
      end
   endtask

   task automatic test_jump_jr();
      auto_mode = 1'b0; man_ack = 1'b0; out_ready = 1'b1;
      do_reset();
      step();
      redirect_valid = 1'b1; redirect_type = 2'b10; redirect_pc_plus4 = 32'h8000_0004; redirect_imm26 = 26'h0000100;
      man_ack = 1'b1;
      step();
      redirect_valid = 1'b0; man_ack = 1'b0;
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
         bad++; $display("FAIL jmp_gap got valid=%b req=%b exp valid=0 req=0", out_valid, imem_req);
      end
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0400) begin
         bad++; $display("FAIL jmp_addr got req=%b addr=%h exp req=1 addr=80000400", imem_req, imem_addr);
      end
      redirect_valid = 1'b1; redirect_type = 2'b11; redirect_reg = 32'h0000_1237;
      step();
      redirect_valid = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0400) begin
         bad++; $display("FAIL jr_keep got req=%b addr=%h exp req=1 addr=80000400", imem_req, imem_addr);
      end
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_1234) begin
         bad++; $display("FAIL jr_addr got valid=%b req=%b addr=%h exp valid=0 req=1 addr=00001234", out_valid, imem_req, imem_addr);
      end
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h1234 || out_instruction !== 32'hDEAD_1234) begin
         bad++; $display("FAIL jr_out got valid=%b pc=%h instr=%h exp valid=1 pc=00001234 instr=dead1234", out_valid, out_pc, out_instruction);
      end
      redirect_valid = 1'b1; redirect_type = 2'b01; redirect_pc_plus4 = 32'h3010; redirect_imm16 = 16'h0004;
      step();
      redirect_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3020) begin
         bad++; $display("FAIL br_fwd got valid=%b req=%b addr=%h exp valid=0 req=1 addr=00003020", out_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_in_hold();
      auto_mode = 1'b1; mem_delay = 4'd0; out_ready = 1'b0;
      do_reset();
      step();
      step();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_type = 2'b10; redirect_pc_plus4 = 32'h0000_0004; redirect_imm26 = 26'h0000020;
      step();
      redirect_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
         bad++; $display("FAIL hr_fetch got valid=%b req=%b addr=%h exp valid=0 req=1 addr=00000080", out_valid, imem_req, imem_addr);
      end
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h80) begin
         bad++; $display("FAIL hr_out got valid=%b pc=%h exp valid=1 pc=00000080", out_valid, out_pc);
      end
   endtask

   task automatic test_wrap();
      auto_mode = 1'b1; mem_delay = 4'd0; out_ready = 1'b1;
      do_reset();
      redirect_valid = 1'b1; redirect_type = 2'b11; redirect_reg = 32'hFFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         bad++; $display("FAIL wrap_boot got req=%b addr=%h exp req=1 addr=fffffffc", imem_req, imem_addr);
      end
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instruction !== 32'h2152_FFFC) begin
         bad++; $display("FAIL wrap_out got valid=%b pc=%h instr=%h exp valid=1 pc=fffffffc instr=2152fffc", out_valid, out_pc, out_instruction);
      end
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         bad++; $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      auto_mode = 1'b0; man_ack = 1'b0; out_ready = 1'b1;
      do_reset();
      step();
      rst_n = 1'b0;
      step();
      total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL rm_reset got req=%b addr=%h valid=%b exp req=0 addr=0 valid=0", imem_req, imem_addr, out_valid);
      end
      rst_n = 1'b1;
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
         bad++; $display("FAIL rm_late_ack got valid=%b req=%b addr=%h exp valid=0 req=1 addr=00003000", out_valid, imem_req, imem_addr);
      end
      step();
      total++; if (out_valid !== 1'b0 || imem_req !== 1'b1) begin
         bad++; $display("FAIL rm_wait got valid=%b req=%b exp valid=0 req=1", out_valid, imem_req);
      end
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b0; auto_mode = 1'b1; mem_delay = 4'd0; man_ack = 1'b0;
      redirect_valid = 1'b0; redirect_type = 2'b00; redirect_pc_plus4 = '0;
      redirect_imm16 = '0; redirect_imm26 = '0; redirect_reg = '0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_hold_stall();
      test_branch();
      test_jump_jr();
      test_redirect_in_hold();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
